// File: rtl/intersection_phase_arbiter.sv
// Round-robin green/yellow/all-red phase arbiter for one intersection shared by
// N_APPROACH roads, with min/max green timing and emergency preempt.
module intersection_phase_arbiter #(
    parameter int N_APPROACH = 4,
    parameter int GREEN_MIN  = 5,
    parameter int GREEN_MAX  = 15,
    parameter int YELLOW_T   = 3,
    parameter int ALLRED_T   = 1,
    parameter int CNT_W      = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic [N_APPROACH-1:0]         req,
    input  logic                          preempt,
    input  logic [$clog2(N_APPROACH)-1:0] preempt_id,
    output logic [N_APPROACH-1:0]         green,
    output logic [N_APPROACH-1:0]         yellow,
    output logic [N_APPROACH-1:0]         red,
    output logic [CNT_W-1:0]              phase_cnt,
    output logic [1:0]                    state_out,
    output logic [$clog2(N_APPROACH)-1:0] grant_id
);
    localparam int GW = $clog2(N_APPROACH);

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_GREEN  = 2'b01;
    localparam logic [1:0] S_YELLOW = 2'b10;
    localparam logic [1:0] S_ALLRED = 2'b11;

    localparam logic [CNT_W-1:0] GMIN_C  = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0] GMAX_C  = CNT_W'(GREEN_MAX);
    localparam logic [CNT_W-1:0] YEL_C   = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] AR_C    = CNT_W'(ALLRED_T);
    localparam logic [GW-1:0]    LAST_ID = GW'(N_APPROACH - 1);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      elapsed_q, elapsed_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [N_APPROACH-1:0] green_q, green_d;
    logic [N_APPROACH-1:0] yellow_q, yellow_d;
    logic [N_APPROACH-1:0] red_q, red_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [N_APPROACH-1:0] grant_mask;
    logic [GW-1:0]         rr_id, winner;
    logic                  rr_found, has_winner, competitor;
    logic [CNT_W-1:0]      el_sat, el_plus;
    int                    rr_sum;

    // Round-robin scan starts just after the current grant; the grant itself is seen last.
    always_comb begin
        rr_found = 1'b0;
        rr_id    = grant_q;
        rr_sum   = 0;
        for (int i = 1; i <= N_APPROACH; i++) begin
            rr_sum = int'(grant_q) + i;
            if (rr_sum >= N_APPROACH) rr_sum = rr_sum - N_APPROACH;
            if (!rr_found && req[GW'(rr_sum)]) begin
                rr_found = 1'b1;
                rr_id    = GW'(rr_sum);
            end
        end
        grant_mask = N_APPROACH'(1) << grant_q;
        winner     = preempt ? preempt_id : rr_id;
        has_winner = preempt || (req != '0);
        competitor = ((req & ~grant_mask) != '0) || (preempt && (preempt_id != grant_q));
    end

    always_comb begin
        state_d   = state_q;
        elapsed_d = elapsed_q;
        grant_d   = grant_q;
        el_sat    = (elapsed_q >= GMAX_C) ? GMAX_C : elapsed_q + 1'b1;
        el_plus   = elapsed_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (has_winner) begin
                    state_d   = S_GREEN;
                    grant_d   = winner;
                    elapsed_d = '0;
                end
            end
            S_GREEN: begin
                if (preempt && (preempt_id != grant_q)) begin
                    state_d   = S_YELLOW;
                    elapsed_d = '0;
                end else if (!preempt && tick) begin
                    elapsed_d = el_sat;
                    if (competitor && ((el_sat == GMAX_C) ||
                                       ((el_sat >= GMIN_C) && !req[grant_q]))) begin
                        state_d   = S_YELLOW;
                        elapsed_d = '0;
                    end
                end
            end
            S_YELLOW: begin
                if (tick) begin
                    if (el_plus >= YEL_C) begin
                        state_d   = S_ALLRED;
                        elapsed_d = '0;
                    end else begin
                        elapsed_d = el_plus;
                    end
                end
            end
            default: begin
                if (tick) begin
                    if (el_plus >= AR_C) begin
                        elapsed_d = '0;
                        if (has_winner) begin
                            state_d = S_GREEN;
                            grant_d = winner;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        elapsed_d = el_plus;
                    end
                end
            end
        endcase

        // Lamps and countdown are derived from the next state so every output is a flop.
        green_d  = (state_d == S_GREEN)  ? (N_APPROACH'(1) << grant_d) : '0;
        yellow_d = (state_d == S_YELLOW) ? (N_APPROACH'(1) << grant_d) : '0;
        red_d    = ~(green_d | yellow_d);
        case (state_d)
            S_GREEN:  cnt_d = (elapsed_d >= GMAX_C) ? '0 : GMAX_C - elapsed_d;
            S_YELLOW: cnt_d = (elapsed_d >= YEL_C)  ? '0 : YEL_C - elapsed_d;
            S_ALLRED: cnt_d = (elapsed_d >= AR_C)   ? '0 : AR_C - elapsed_d;
            default:  cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            elapsed_q <= '0;
            grant_q   <= LAST_ID;
            green_q   <= '0;
            yellow_q  <= '0;
            red_q     <= '1;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            elapsed_q <= elapsed_d;
            grant_q   <= grant_d;
            green_q   <= green_d;
            yellow_q  <= yellow_d;
            red_q     <= red_d;
            cnt_q     <= cnt_d;
        end
    end

    assign green     = green_q;
    assign yellow    = yellow_q;
    assign red       = red_q;
    assign phase_cnt = cnt_q;
    assign state_out = state_q;
    assign grant_id  = grant_q;
endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// Bench for intersection_phase_arbiter: directed scenarios plus random traffic,
// checked against a phase/countdown reference model through an expected queue.
module tb_intersection_phase_arbiter;
    localparam int N    = 4;
    localparam int GMIN = 5;
    localparam int GMAX = 15;
    localparam int YT   = 3;
    localparam int AT   = 1;
    localparam int CW   = 5;
    localparam int GW   = 2;
    localparam int W    = 2 + GW + CW + 3 * N;

    logic          clk = 1'b0;
    logic          rst, tick, preempt;
    logic [N-1:0]  req;
    logic [GW-1:0] preempt_id;
    logic [N-1:0]  green, yellow, red;
    logic [CW-1:0] phase_cnt;
    logic [1:0]    state_out;
    logic [GW-1:0] grant_id;

    always #5 clk = ~clk;

    intersection_phase_arbiter #(
        .N_APPROACH(N), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
        .YELLOW_T(YT), .ALLRED_T(AT), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .req(req),
        .preempt(preempt), .preempt_id(preempt_id),
        .green(green), .yellow(yellow), .red(red),
        .phase_cnt(phase_cnt), .state_out(state_out), .grant_id(grant_id)
    );

    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit done    = 1'b0;

    // Reference model: phase 0 idle, 1 green, 2 yellow, 3 all-red.
    int m_phase, m_grant, m_age, m_left;

    task automatic model_step(input logic r, input logic t, input logic [N-1:0] rq,
                              input logic p, input logic [GW-1:0] pid);
        int  win;
        bit  has, comp;
        win = m_grant;
        if (p) win = int'(pid);
        else begin
            for (int k = N; k >= 1; k--)
                if (rq[(m_grant + k) % N]) win = (m_grant + k) % N;
        end
        has  = p || (rq != 0);
        comp = p && (int'(pid) != m_grant);
        for (int c = 0; c < N; c++)
            if (c != m_grant && rq[c]) comp = 1'b1;
        if (r) begin
            m_phase = 0; m_grant = N - 1; m_age = 0; m_left = 0;
        end else begin
            case (m_phase)
                0: if (has) begin m_phase = 1; m_grant = win; m_age = 0; end
                1: begin
                    if (p && int'(pid) != m_grant) begin
                        m_phase = 2; m_left = YT;
                    end else if (!p && t) begin
                        if (m_age < GMAX) m_age++;
                        if (comp && (m_age == GMAX || (m_age >= GMIN && !rq[m_grant]))) begin
                            m_phase = 2; m_left = YT;
                        end
                    end
                end
                2: if (t) begin
                    m_left--;
                    if (m_left == 0) begin m_phase = 3; m_left = AT; end
                end
                default: if (t) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (has) begin m_phase = 1; m_grant = win; m_age = 0; end
                        else m_phase = 0;
                    end
                end
            endcase
        end
    endtask

    function automatic logic [W-1:0] model_out();
        logic [N-1:0]  g, y;
        logic [CW-1:0] c;
        g = '0; y = '0; c = '0;
        if (m_phase == 1) begin g[m_grant] = 1'b1; c = CW'(GMAX - m_age); end
        if (m_phase == 2) begin y[m_grant] = 1'b1; c = CW'(m_left); end
        if (m_phase == 3) c = CW'(m_left);
        return {2'(m_phase), GW'(m_grant), c, ~(g | y), y, g};
    endfunction

    task automatic cycle(input logic r, input logic t, input logic [N-1:0] rq,
                         input logic p, input logic [GW-1:0] pid);
        rst = r; tick = t; req = rq; preempt = p; preempt_id = pid;
        model_step(r, t, rq, p, pid);
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic run_ticks(input int n, input logic [N-1:0] rq,
                             input logic p, input logic [GW-1:0] pid);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b1, rq, p, pid);
            cycle(1'b0, 1'b0, rq, p, pid);
        end
    endtask

    // Monitor: every clock the DUT presents a full output word.
    initial begin
        logic [W-1:0] act, e;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            cyc++;
            act = {state_out, grant_id, phase_cnt, red, yellow, green};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL exp_empty cyc=%0d got=%h required=an expected entry", cyc, act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL outputs cyc=%0d got st=%0d gid=%0d cnt=%0d r=%b y=%b g=%b required st=%0d gid=%0d cnt=%0d r=%b y=%b g=%b",
                             cyc, act[W-1 -: 2], act[W-3 -: GW], act[3*N +: CW], act[2*N +: N], act[N +: N], act[0 +: N],
                             e[W-1 -: 2], e[W-3 -: GW], e[3*N +: CW], e[2*N +: N], e[N +: N], e[0 +: N]);
                end
            end
            n_tests++;
            if (($countones(green | yellow) > 1) || (red !== ~(green | yellow))) begin
                n_fail++;
                $display("FAIL lamp_invariant cyc=%0d got g=%b y=%b r=%b required one-hot lamps and r=~(g|y)",
                         cyc, green, yellow, red);
            end
        end
    end

    initial begin
        logic [N-1:0]  rq;
        logic          p;
        logic [GW-1:0] pid;
        m_phase = 0; m_grant = N - 1; m_age = 0; m_left = 0;

        cycle(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
        cycle(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
        run_ticks(50, 4'b0000, 1'b0, 2'd0);

        cycle(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
        run_ticks(40, 4'b0001, 1'b0, 2'd0);

        cycle(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
        run_ticks(90, 4'b0011, 1'b0, 2'd0);

        cycle(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
        cycle(1'b0, 1'b0, 4'b0101, 1'b0, 2'd0);
        run_ticks(2, 4'b0101, 1'b0, 2'd0);
        run_ticks(30, 4'b0100, 1'b0, 2'd0);

        cycle(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
        cycle(1'b0, 1'b0, 4'b0001, 1'b0, 2'd0);
        run_ticks(1, 4'b0001, 1'b0, 2'd0);
        run_ticks(20, 4'b0001, 1'b1, 2'd3);
        run_ticks(5, 4'b0001, 1'b0, 2'd0);

        cycle(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
        run_ticks(17, 4'b0011, 1'b0, 2'd0);
        cycle(1'b1, 1'b0, 4'b0011, 1'b0, 2'd0);
        run_ticks(20, 4'b1001, 1'b0, 2'd0);

        rq = '0; p = 1'b0; pid = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) rq = N'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) begin
                p   = ~p;
                pid = GW'($urandom_range(0, N - 1));
            end
            cycle($urandom_range(0, 499) == 0, $urandom_range(0, 2) == 0, rq, p, pid);
        end

        done = 1'b1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d leftover entries required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/intersection_phase_arbiter.md
# intersection_phase_arbiter

Round-robin phase arbiter that shares one intersection between N approach roads, each with its own vehicle sensor. It grants green to exactly one approach at a time and sequences green -> yellow -> all-red clearance. It enforces minimum and maximum green times and supports an emergency-vehicle preempt. It sits between the sensor and debounce logic and the per-approach lamp drivers and seven-segment countdown decoders, and is timed by a 1 Hz `tick` strobe from the clock divider.

## Interface
Parameters:
- N_APPROACH, 4: number of approaches (2..8).
- GREEN_MIN, 5: minimum green, in ticks.
- GREEN_MAX, 15: maximum green under competing demand, in ticks.
- YELLOW_T, 3: yellow duration, in ticks.
- ALLRED_T, 1: all-red clearance duration, in ticks.
- CNT_W, 5: width of the phase counter and of `phase_cnt`. Every timing parameter must be < 2^CNT_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- tick  in  1  one-clk timing strobe, nominally 1 Hz.
- req  in  N_APPROACH  vehicle-present level per approach.
- preempt  in  1  emergency preempt, level.
- preempt_id  in  $clog2(N_APPROACH)  approach requested by the preempt.
- green  out  N_APPROACH  one-hot or zero.
- yellow  out  N_APPROACH  one-hot or zero.
- red  out  N_APPROACH  equal to ~(green|yellow).
- phase_cnt  out  CNT_W  ticks remaining in the current phase, for display.
- state_out  out  2  00 IDLE, 01 GREEN, 10 YELLOW, 11 ALLRED.
- grant_id  out  $clog2(N_APPROACH)  approach currently or last served.

## Operation
- All outputs are registered.
- Reset values: state IDLE, green=0, yellow=0, red=all 1s, phase_cnt=0, grant_id=N_APPROACH-1, elapsed=0.
  - With grant_id at N_APPROACH-1, approach 0 wins first under round-robin.
- Winner selection:
  - If `preempt` is high, the winner is `preempt_id`.
  - Otherwise the winner is the first set bit of `req` scanning grant_id+1, grant_id+2, ... with wrap-around. grant_id itself is scanned last.
- Competitor: any set bit of `req` other than grant_id, or `preempt` high with preempt_id ≠ grant_id.
- IDLE:
  - All red. State is not tick-gated.
  - If req≠0 or preempt is high, go to GREEN next clk: grant_id=winner, elapsed=0.
- GREEN (only `green[grant_id]` is set). On each tick, elapsed increments, saturating at GREEN_MAX. Exit rules:
  - Preempt for another approach: go to YELLOW on the next clk, no tick needed, GREEN_MIN is ignored.
  - Preempt for grant_id: stay in GREEN and freeze elapsed.
  - Gap-out: on a tick where the new elapsed ≥ GREEN_MIN, a competitor exists, and req[grant_id]=0, go to YELLOW.
  - Max-out: on a tick where the new elapsed = GREEN_MAX and a competitor exists, go to YELLOW.
  - No competitor: rest in GREEN indefinitely, with elapsed saturated.
- YELLOW: after YELLOW_T ticks, go to ALLRED. Preempt does not shorten YELLOW.
- ALLRED:
  - After ALLRED_T ticks, if a winner exists (req≠0 or preempt), go to GREEN with grant_id=winner and elapsed=0; otherwise go to IDLE.
  - The same approach may be re-granted when it is the only requester.
- phase_cnt shows the ticks remaining in the phase:
  - GREEN: GREEN_MAX − elapsed, which reads 0 while resting.
  - YELLOW: YELLOW_T − elapsed.
  - ALLRED: ALLRED_T − elapsed.
  - IDLE: 0.
  - Arithmetic is unsigned CNT_W and never underflows.
- Invariants:
  - popcount(green|yellow) ≤ 1.
  - green and yellow are never both set.
  - Every GREEN is preceded by ALLRED or IDLE.

## Timing
- Phase exits caused by a tick occur on the same clk edge that samples the tick. Outputs change on that edge plus one register.
- IDLE→GREEN latency is 1 clk from `req` being sampled high.
- Preempt into YELLOW takes 1 clk.
- Simultaneous tick and req change: the `req` value sampled on that edge is the one used.
- Simultaneous tick and preempt in GREEN: the preempt rule wins.
- `rst` mid-phase: the next edge forces all outputs to their reset values, even from GREEN (all-red is acceptable).
- `tick` held high for k clks counts as k ticks. The bench drives single-clk strobes.

## Test plan
- Reset then req=4'b0000 for 50 ticks -> IDLE, red=4'b1111, phase_cnt=0 throughout.
- req=4'b0001 from reset -> green=4'b0001 one clk later; with no competitor it stays green for 40 ticks and phase_cnt reaches 0.
- req=4'b0011 constant -> green0 for 15 ticks (max-out), yellow 3, all-red 1, green1 for 15, and so on, strictly alternating.
- req=4'b0101, then req[0] drops at tick 2 -> YELLOW at tick 5 (gap-out at GREEN_MIN), then green=4'b0100.
- In GREEN on approach 0 at tick 1, preempt=1 with id=3 -> yellow=4'b0001 next clk, 3 ticks yellow, 1 tick all-red, then green=4'b1000; green on 3 holds while preempt stays high.
- rst asserted mid-YELLOW -> next clk yellow=0, red=4'b1111, grant_id=3; after release with req=4'b1001, approach 0 is granted first.
